// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - state_e  : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   - KEY_MAP  : key code per [row][col], row-major
//                1 2 3 A / 4 5 6 B / 7 8 9 C / E(*) 0 F(#) D
//   - width constants and small column-decode helpers
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEY_W = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_e;

  localparam logic [KEY_W-1:0] KEY_MAP [ROWS][COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Columns are active-low: true when exactly one column is pulled down.
  function automatic logic one_low(input logic [COLS-1:0] v);
    return $countones(~v) == 1;
  endfunction

  // Index of the (single) low column.
  function automatic logic [IDX_W-1:0] low_index(input logic [COLS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (!v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// keypad_scanner_if
// Pin-side and lock-FSM-side signals of the keypad scanner.
//   row          : row drive, active-low, one-cold
//   col          : column sense, active-low, asynchronous
//   keyboard_num : code of the last accepted key
//   keyboard_en  : one-clock pulse per accepted key
//   key_held     : high while the accepted key is still down
// master = scanner side, slave = board/consumer side.
// -----------------------------------------------------------------------------
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [ROWS-1:0]  row;
  logic [COLS-1:0]  col;
  logic [KEY_W-1:0] keyboard_num;
  logic             keyboard_en;
  logic             key_held;

  modport master (
    output row, keyboard_num, keyboard_en, key_held,
    input  col
  );

  modport slave (
    input  row, keyboard_num, keyboard_en, key_held,
    output col
  );
endinterface

// File: rtl/keypad_scanner_counter.sv
// -----------------------------------------------------------------------------
// counter
// Free-running wrap counter used as the scan tick divider.
//   clk, rst : clock, synchronous active-low reset
//   cnt_inc  : advance enable
//   cnt_end  : high for the cycle in which the count equals MAX (wraps to 0)
// -----------------------------------------------------------------------------
module counter #(
  parameter int          W   = 18,
  parameter int unsigned MAX = 200000 - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_inc,
  output logic cnt_end
);

  logic [W-1:0] cnt;

  assign cnt_end = cnt_inc && (cnt == W'(MAX));

  // NOTE: sequential state is updated with <= only, so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst)         cnt <= '0;
    else if (cnt_inc) cnt <= cnt_end ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row per tick, debounces press and
// release, and emits one registered keyboard_num/keyboard_en pulse per
// accepted key.
//   clk : system clock
//   rst : synchronous, active-low reset
//   kp  : keypad_scanner_if.master (row, col, keyboard_num, keyboard_en,
//         key_held)
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse the held key every
// REPEAT_SCANS ticks.
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 200000 - 1,
  parameter int          CNT_W          = 18,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input logic              clk,
  input logic              rst,
  keypad_scanner_if.master kp
);

  if (DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1 || SCAN_DIV >= (64'd1 << CNT_W))
  begin : g_bad_cfg
    $error("keypad_scanner: invalid parameter set");
  end

  // One spare bit so the incremented count never wraps before the compare.
  localparam int DB_W = $clog2(DEBOUNCE_SCANS + 1) + 1;
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  logic             tick;
  logic [COLS-1:0]  col_m, col_s;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] r_q, r_d, c_q, c_d;
  logic [COLS-1:0]  pat_q, pat_d;
  logic [DB_W-1:0]  press_q, press_d, rel_q, rel_d;
  logic             accept;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [RP_W-1:0] RP_TARGET = RP_W'(REPEAT_SCANS);
  logic [RP_W-1:0] rep_q, rep_d;
`endif

  counter #(.W(CNT_W), .MAX(SCAN_DIV)) u_div (
    .clk     (clk),
    .rst     (rst),
    .cnt_inc (1'b1),
    .cnt_end (tick)
  );

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    pat_d   = pat_q;
    press_d = press_q;
    rel_d   = rel_q;
    accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (one_low(col_s)) begin
            // Row pointer stays frozen on the pressed row until release.
            c_d     = low_index(col_s);
            pat_d   = col_s;
            press_d = DB_W'(1);
            state_d = DEBOUNCE;
          end else begin
            r_d = r_q + IDX_W'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s == pat_q) begin
            if (press_q + DB_W'(1) >= DB_TARGET) begin
              accept  = 1'b1;
              press_d = '0;
              rel_d   = '0;
              state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              press_d = press_q + DB_W'(1);
            end
          end else begin
            press_d = '0;
            r_d     = r_q + IDX_W'(1);
            state_d = SCAN;
          end
        end
        HELD: begin
          if (&col_s) begin
            if (rel_q + DB_W'(1) >= DB_TARGET) begin
              rel_d   = '0;
              r_d     = r_q + IDX_W'(1);
              state_d = SCAN;
            end else begin
              rel_d = rel_q + DB_W'(1);
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d = '0;
`endif
          end else begin
            rel_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_q + RP_W'(1) == RP_TARGET) begin
              accept = 1'b1;
              rep_d  = '0;
            end else begin
              rep_d = rep_q + RP_W'(1);
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // NOTE: all state, including the synchronizer, is reset so a reset in
  // DEBOUNCE or HELD cleanly discards the key; KEY_MAP is a constant, not a
  // memory, and needs no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_m           <= '1;
      col_s           <= '1;
      state_q         <= SCAN;
      r_q             <= '0;
      c_q             <= '0;
      pat_q           <= '1;
      press_q         <= '0;
      rel_q           <= '0;
      kp.row          <= 4'b1110;
      kp.keyboard_num <= '0;
      kp.keyboard_en  <= 1'b0;
      kp.key_held     <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q           <= '0;
`endif
    end else begin
      col_m          <= kp.col;
      col_s          <= col_m;
      state_q        <= state_d;
      r_q            <= r_d;
      c_q            <= c_d;
      pat_q          <= pat_d;
      press_q        <= press_d;
      rel_q          <= rel_d;
      kp.row         <= ~(4'b0001 << r_d);
      kp.keyboard_en <= accept;
      kp.key_held    <= (state_d == HELD);
      if (accept) kp.keyboard_num <= KEY_MAP[r_q][c_q];
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q          <= rep_d;
`endif
    end
  end

endmodule
